// File: rtl/lif_pkg.sv
// lif_pkg -- shared definitions for the leaky integrate-and-fire core.
//   Widths of a spike row, a synaptic weight, the membrane and a row sum,
//   the controller state type and the saturating membrane add.
package lif_pkg;

  localparam int ROW_W  = 24;  // pre-synaptic spikes per row, weights per BRAM word
  localparam int WGT_W  = 8;   // signed weight width
  localparam int VMEM_W = 16;  // signed membrane width
  localparam int SUM_W  = 13;  // signed row-sum width, holds +/-24*128
  localparam int REFR_W = 3;
  localparam logic [REFR_W-1:0] REFR_LOAD = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ACCUM   = 2'd2,
    ST_FIRE    = 2'd3
  } lif_state_e;

  // Membrane plus row sum, clamped to the signed membrane range.
  function automatic logic signed [VMEM_W-1:0] sat_add(
    input logic signed [VMEM_W-1:0] v,
    input logic signed [SUM_W-1:0]  s
  );
    logic [VMEM_W:0] t;
    t = {v[VMEM_W-1], v} + {{(VMEM_W+1-SUM_W){s[SUM_W-1]}}, s};
    // Overflow shows up as disagreement between the two top bits.
    if (t[VMEM_W] != t[VMEM_W-1])
      sat_add = t[VMEM_W] ? {1'b1, {(VMEM_W-1){1'b0}}} : {1'b0, {(VMEM_W-1){1'b1}}};
    else
      sat_add = t[VMEM_W-1:0];
  endfunction

endpackage

// File: rtl/lif_core_row_dot.sv
// row_dot -- combinational masked dot product of one spike row with one
//   BRAM word of signed weights.
//   spikes_i  : spike row, bit k selects weight k
//   weights_i : ROW_W packed signed weights, weight k at [k*WGT_W +: WGT_W]
//   sum_o     : signed sum of the selected weights
module row_dot
  import lif_pkg::*;
(
  input  logic [ROW_W-1:0]        spikes_i,
  input  logic [ROW_W*WGT_W-1:0]  weights_i,
  output logic signed [SUM_W-1:0] sum_o
);

  logic signed [WGT_W-1:0] w;

  always_comb begin
    sum_o = '0;
    w     = '0;
    for (int k = 0; k < ROW_W; k++) begin
      w = weights_i[k*WGT_W +: WGT_W];
      if (spikes_i[k]) sum_o = sum_o + SUM_W'(w);
    end
  end

endmodule

// File: rtl/lif_core.sv
// lif_core -- leaky integrate-and-fire layer controller.
//   Captures 24 spike rows per sample period, streams NPOST*24 weight words
//   from an external BRAM, integrates each masked row sum into a saturating
//   per-neuron membrane, then fires/leaks all neurons in one cycle.
//
//   State | meaning
//   IDLE    | waiting for i_syn_run
//   CAPTURE | storing 24 valid spike rows
//   ACCUM   | issuing reads, integrating returned words (1-cycle latency)
//   FIRE    | threshold compare, reset-on-fire or leak, publish spikes
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   i_syn_run             : start of a sample period (honoured in IDLE only)
//   i_spike_bundle/i_valid: spike row input and its qualifier
//   o_addr/o_ce/o_we/i_q  : weight BRAM read port, word = n*24 + r
//   o_post_spike/o_valid  : fire flags of the last period and update pulse
//   o_busy                : high whenever the controller is not IDLE
//
// Build option: define LIF_REFRACTORY_EN to add a per-neuron refractory
//   counter (loaded with 4 on fire, skips integration and leak while
//   nonzero, counts down once per FIRE).
module lif_core
  import lif_pkg::*;
#(
  parameter int                        NPOST      = 10,
  parameter logic signed [VMEM_W-1:0]  V_TH       = 16'sd1024,
  parameter int                        LEAK_SHIFT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_syn_run,
  input  logic [ROW_W-1:0]         i_spike_bundle,
  input  logic                     i_valid,
  output logic [7:0]               o_addr,
  output logic                     o_ce,
  output logic                     o_we,
  input  logic [ROW_W*WGT_W-1:0]   i_q,
  output logic [NPOST-1:0]         o_post_spike,
  output logic                     o_valid,
  output logic                     o_busy
);

  localparam int NW = (NPOST > 1) ? $clog2(NPOST) : 1;
  localparam int CW = $clog2(ROW_W);

  lif_state_e               state_q;
  logic [CW-1:0]            cap_cnt_q;
  logic [ROW_W-1:0]         rows_q [ROW_W];
  logic [NW-1:0]            n_q;
  logic [CW-1:0]            r_q;
  logic [7:0]               addr_q;
  logic                     ce_q;
  logic                     pend_q;
  logic [NW-1:0]            pend_n_q;
  logic [CW-1:0]            pend_r_q;
  logic signed [VMEM_W-1:0] vmem_q [NPOST];
  logic [NPOST-1:0]         spike_q;
  logic                     valid_q;
  logic signed [SUM_W-1:0]  row_sum;
`ifdef LIF_REFRACTORY_EN
  logic [REFR_W-1:0]        refr_q [NPOST];
`endif

  // The word arriving on i_q belongs to the address issued one cycle ago,
  // so the row mask follows the delayed row index.
  row_dot u_row_dot (
    .spikes_i  (rows_q[pend_r_q]),
    .weights_i (i_q),
    .sum_o     (row_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cap_cnt_q <= '0;
      n_q       <= '0;
      r_q       <= '0;
      addr_q    <= '0;
      ce_q      <= 1'b0;
      pend_q    <= 1'b0;
      pend_n_q  <= '0;
      pend_r_q  <= '0;
      spike_q   <= '0;
      valid_q   <= 1'b0;
      for (int i = 0; i < ROW_W; i++) rows_q[i] <= '0;
      for (int n = 0; n < NPOST; n++) begin
        vmem_q[n] <= '0;
`ifdef LIF_REFRACTORY_EN
        refr_q[n] <= '0;
`endif
      end
    end else begin
      valid_q  <= 1'b0;
      pend_q   <= ce_q;
      pend_n_q <= n_q;
      pend_r_q <= r_q;

      case (state_q)
        ST_IDLE: begin
          if (i_syn_run) begin
            state_q   <= ST_CAPTURE;
            cap_cnt_q <= '0;
          end
        end

        ST_CAPTURE: begin
          if (i_valid) begin
            rows_q[cap_cnt_q] <= i_spike_bundle;
            if (cap_cnt_q == CW'(ROW_W-1)) begin
              state_q   <= ST_ACCUM;
              cap_cnt_q <= '0;
              ce_q      <= 1'b1;
              addr_q    <= '0;
              n_q       <= '0;
              r_q       <= '0;
            end else begin
              cap_cnt_q <= cap_cnt_q + CW'(1);
            end
          end
        end

        ST_ACCUM: begin
          if (ce_q) begin
            if (n_q == NW'(NPOST-1) && r_q == CW'(ROW_W-1)) begin
              ce_q <= 1'b0;
            end else begin
              addr_q <= addr_q + 8'd1;
              if (r_q == CW'(ROW_W-1)) begin
                r_q <= '0;
                n_q <= n_q + NW'(1);
              end else begin
                r_q <= r_q + CW'(1);
              end
            end
          end
          if (pend_q) begin
`ifdef LIF_REFRACTORY_EN
            if (refr_q[pend_n_q] == '0)
              vmem_q[pend_n_q] <= sat_add(vmem_q[pend_n_q], row_sum);
`else
            vmem_q[pend_n_q] <= sat_add(vmem_q[pend_n_q], row_sum);
`endif
            // Reads have stopped and this is the final returned word.
            if (!ce_q) state_q <= ST_FIRE;
          end
        end

        ST_FIRE: begin
          for (int n = 0; n < NPOST; n++) begin
`ifdef LIF_REFRACTORY_EN
            if (refr_q[n] != '0) begin
              refr_q[n]  <= refr_q[n] - REFR_W'(1);
              spike_q[n] <= 1'b0;
            end else
`endif
            if (vmem_q[n] >= V_TH) begin
              spike_q[n] <= 1'b1;
              vmem_q[n]  <= '0;
`ifdef LIF_REFRACTORY_EN
              refr_q[n]  <= REFR_LOAD;
`endif
            end else begin
              spike_q[n] <= 1'b0;
              vmem_q[n]  <= vmem_q[n] - (vmem_q[n] >>> LEAK_SHIFT);
            end
          end
          valid_q <= 1'b1;
          addr_q  <= '0;
          n_q     <= '0;
          r_q     <= '0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_addr       = addr_q;
  assign o_ce         = ce_q;
  assign o_we         = 1'b0;
  assign o_post_spike = spike_q;
  assign o_valid      = valid_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule
